// File: rtl/link_frame_master_if.sv
// rtl/link_frame_master_if.sv - host and serial-link signal bundle for link_frame_master
// LNK_AUTO_RESTART_EN adds the auto_en input.
interface link_frame_master_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             tx_we;
    logic [1:0]       tx_idx;
    logic [31:0]      tx_wdata;
    logic [1:0]       rx_idx;
    logic [31:0]      rx_rdata;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;
    logic             lnk_clk;
    logic             lnk_sync_en;
    logic             lnk_dout;
    logic             lnk_din;
`ifdef LNK_AUTO_RESTART_EN
    logic             auto_en;

    modport master (
        input  start, tx_we, tx_idx, tx_wdata, rx_idx, lnk_din, auto_en,
        output rx_rdata, busy, done, frame_cnt, lnk_clk, lnk_sync_en, lnk_dout
    );
    modport slave (
        output start, tx_we, tx_idx, tx_wdata, rx_idx, lnk_din, auto_en,
        input  rx_rdata, busy, done, frame_cnt, lnk_clk, lnk_sync_en, lnk_dout
    );
`else
    modport master (
        input  start, tx_we, tx_idx, tx_wdata, rx_idx, lnk_din,
        output rx_rdata, busy, done, frame_cnt, lnk_clk, lnk_sync_en, lnk_dout
    );
    modport slave (
        output start, tx_we, tx_idx, tx_wdata, rx_idx, lnk_din,
        input  rx_rdata, busy, done, frame_cnt, lnk_clk, lnk_sync_en, lnk_dout
    );
`endif
endinterface

// File: rtl/link_frame_master.sv
// rtl/link_frame_master.sv - master sequencer for the 1-bit serial register link (4 words each way per frame)
// Optional LNK_AUTO_RESTART_EN: auto_en=1 chains frames back to back without a new start.
module link_frame_master #(
    parameter int CLK_HALF = 2,
    parameter int CNT_W    = 16
) (
    input logic                  clk_sys,
    input logic                  sys_reset_n,
    link_frame_master_if.master  bus
);
    localparam int PH_W = (CLK_HALF > 1) ? $clog2(2 * CLK_HALF) : 1;
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_HALF);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_HALF - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, CLOSE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       seg_q, seg_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [31:0]      tx_word_q [4];
    logic [31:0]      tx_word_d [4];
    logic [31:0]      rx_word_q [4];
    logic [31:0]      rx_word_d [4];
    logic [31:0]      tx_shift_q, tx_shift_d;
    logic [31:0]      rx_shift_q, rx_shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lnk_clk_q, lnk_clk_d;
    logic             lnk_sync_q, lnk_sync_d;
    logic             lnk_dout_q, lnk_dout_d;
    logic             edge_end;
    logic             restart;

`ifdef LNK_AUTO_RESTART_EN
    assign restart = bus.auto_en;
`else
    assign restart = 1'b0;
`endif

    assign edge_end = (ph_q == PH_LAST);

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        bit_idx_d  = bit_idx_q;
        ph_d       = ph_q;
        tx_word_d  = tx_word_q;
        rx_word_d  = rx_word_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        lnk_sync_d = lnk_sync_q;
        lnk_dout_d = lnk_dout_q;

        if (bus.tx_we) tx_word_d[bus.tx_idx] = bus.tx_wdata;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SYNC;
                    seg_d      = 2'd0;
                    ph_d       = '0;
                    busy_d     = 1'b1;
                    lnk_sync_d = 1'b1;
                    lnk_dout_d = 1'b0;
                end
            end
            SYNC: begin
                // A host write to the slot being snapshotted this cycle takes precedence.
                if (ph_q == '0)
                    tx_shift_d = (bus.tx_we && bus.tx_idx == seg_q) ? bus.tx_wdata : tx_word_q[seg_q];
                if (edge_end) begin
                    state_d    = SHIFT;
                    bit_idx_d  = 5'd0;
                    ph_d       = '0;
                    lnk_sync_d = 1'b0;
                    lnk_dout_d = tx_shift_q[0];
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT: begin
                if (ph_q == PH_RISE) rx_shift_d = {bus.lnk_din, rx_shift_q[31:1]};
                if (edge_end) begin
                    ph_d = '0;
                    if (bit_idx_q == 5'd31) begin
                        rx_word_d[seg_q] = rx_shift_q;
                        seg_d      = seg_q + 2'd1;
                        lnk_sync_d = 1'b1;
                        lnk_dout_d = 1'b0;
                        state_d    = (seg_q == 2'd3) ? CLOSE : SYNC;
                    end else begin
                        bit_idx_d  = bit_idx_q + 5'd1;
                        tx_shift_d = {1'b0, tx_shift_q[31:1]};
                        lnk_dout_d = tx_shift_q[1];
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            CLOSE: begin
                if (edge_end) begin
                    ph_d       = '0;
                    done_d     = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    lnk_dout_d = 1'b0;
                    if (restart) begin
                        state_d    = SYNC;
                        seg_d      = 2'd0;
                        lnk_sync_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        lnk_sync_d = 1'b0;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // lnk_clk is derived from the next phase so the registered output lines up with the phase counter.
        lnk_clk_d = (state_d != IDLE) && (ph_d >= PH_HIGH);
    end

    always_ff @(posedge clk_sys or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q    <= IDLE;
            seg_q      <= 2'd0;
            bit_idx_q  <= 5'd0;
            ph_q       <= '0;
            tx_word_q  <= '{default: '0};
            rx_word_q  <= '{default: '0};
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            lnk_clk_q  <= 1'b0;
            lnk_sync_q <= 1'b0;
            lnk_dout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            bit_idx_q  <= bit_idx_d;
            ph_q       <= ph_d;
            tx_word_q  <= tx_word_d;
            rx_word_q  <= rx_word_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            lnk_clk_q  <= lnk_clk_d;
            lnk_sync_q <= lnk_sync_d;
            lnk_dout_q <= lnk_dout_d;
        end
    end

    assign bus.rx_rdata    = rx_word_q[bus.rx_idx];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frame_cnt   = cnt_q;
    assign bus.lnk_clk     = lnk_clk_q;
    assign bus.lnk_sync_en = lnk_sync_q;
    assign bus.lnk_dout    = lnk_dout_q;
endmodule

// File: tb/tb_link_frame_master.sv
// tb/tb_link_frame_master.sv - randomized frames against a behavioural link slave and word-level model
module tb_link_frame_master;
    localparam int CLK_HALF  = 2;
    localparam int CNT_W     = 4;
    localparam int FRAME_CYC = 133 * 2 * CLK_HALF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    link_frame_master_if #(.CNT_W(CNT_W)) bus();

    link_frame_master #(.CLK_HALF(CLK_HALF), .CNT_W(CNT_W)) dut (
        .clk_sys     (clk),
        .sys_reset_n (rst_n),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference state: host-visible tx words, slave registers, completed frames
    logic [31:0] tx_model [4];
    logic [31:0] s_out [4];
    logic [31:0] s_in [4];
    logic [31:0] s_in_sh = '0;
    logic [31:0] s_out_sh = '0;
    logic [1:0]  s_slot = '0;
    logic        loopback = 1'b1;
    int          exp_cnt = 0;

    int   n_rise_sync, n_rise_data, n_viol, n_done;
    logic prev_clk = 1'b0, prev_sync = 1'b0, prev_dout = 1'b0;

    assign bus.lnk_din = loopback ? bus.lnk_dout : s_out_sh[0];

    // Behavioural slave plus link-protocol monitor, evaluated away from the active edge
    always @(negedge clk) begin
        if (!rst_n || !bus.busy) s_slot = 2'd0;
        if (rst_n && bus.lnk_clk && !prev_clk) begin
            if (bus.lnk_sync_en) begin
                n_rise_sync++;
                s_in[s_slot] = s_in_sh;
                s_out_sh     = s_out[s_slot];
                s_slot       = s_slot + 2'd1;
            end else begin
                n_rise_data++;
                s_in_sh  = {bus.lnk_dout, s_in_sh[31:1]};
                s_out_sh = s_out_sh >> 1;
            end
        end
        if (bus.lnk_clk && prev_clk && (bus.lnk_sync_en !== prev_sync || bus.lnk_dout !== prev_dout))
            n_viol++;
        if (bus.done) n_done++;
        prev_clk  = bus.lnk_clk;
        prev_sync = bus.lnk_sync_en;
        prev_dout = bus.lnk_dout;
    end

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        @(negedge clk);
        bus.tx_we = 1'b1; bus.tx_idx = idx; bus.tx_wdata = d;
        tx_model[idx] = d;
        @(negedge clk);
        bus.tx_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        @(negedge clk);
        bus.rx_idx = idx;
        #1;
        chk(tag, bus.rx_rdata, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_lnk_clk"}, bus.lnk_clk, 0);
        chk({tag, "_sync"}, bus.lnk_sync_en, 0);
        chk({tag, "_dout"}, bus.lnk_dout, 0);
        chk({tag, "_frame_cnt"}, bus.frame_cnt, 0);
    endtask

    task automatic run_frame(input bit inj, input int rst_at);
        int c;
        bit got;
        n_rise_sync = 0; n_rise_data = 0; n_viol = 0; n_done = 0;
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        c = 0; got = 1'b0;
        while (!got && c < 2 * FRAME_CYC) begin
            @(posedge clk); c++;
            @(negedge clk);
            if (rst_at != 0 && c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_idle_outputs("midreset");
                exp_cnt = 0;
                for (int k = 0; k < 4; k++) tx_model[k] = '0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) rd("midreset_rx", 2'(k), 32'h0);
                return;
            end
            if (inj) begin
                bus.start = (c == 300);
                bus.tx_we = (c == 180);
                if (c == 180) begin
                    bus.tx_idx = 2'd3; bus.tx_wdata = 32'h55; tx_model[3] = 32'h55;
                end
            end
            got = bus.done;
        end
        chk("frame_len", c, FRAME_CYC);
        exp_cnt++;
        chk("frame_cnt", bus.frame_cnt, 32'(exp_cnt % (1 << CNT_W)));
        @(negedge clk);
        chk("done_width", bus.done, 0);
        chk("busy_end", bus.busy, 0);
        chk("lnk_clk_end", bus.lnk_clk, 0);
        repeat (inj ? FRAME_CYC + 20 : 6) @(negedge clk);
        chk("done_count", n_done, 1);
        chk("sync_rises", n_rise_sync, 5);
        chk("data_rises", n_rise_data, 128);
        chk("edge_stability", n_viol, 0);
        for (int k = 0; k < 4; k++)
            rd("rx_word", 2'(k), loopback ? tx_model[k] : s_out[k]);
        if (!loopback)
            for (int k = 0; k < 4; k++) chk("slave_in", s_in[(k + 1) % 4], tx_model[k]);
    endtask

`ifdef LNK_AUTO_RESTART_EN
    task automatic auto_test();
        int c;
        bit got, busy_ok;
        loopback = 1'b1;
        bus.auto_en = 1'b1;
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        for (int f = 0; f < 4; f++) begin
            if (f == 3) bus.auto_en = 1'b0;
            c = 0; got = 1'b0; busy_ok = 1'b1;
            while (!got && c < 2 * FRAME_CYC) begin
                @(posedge clk); c++;
                @(negedge clk);
                got = bus.done;
                if (!bus.busy) busy_ok = 1'b0;
            end
            chk("auto_period", c, FRAME_CYC);
            chk("auto_busy", busy_ok, 1);
            exp_cnt++;
            chk("auto_frame_cnt", bus.frame_cnt, 32'(exp_cnt % (1 << CNT_W)));
        end
        @(negedge clk);
        chk("auto_stop_busy", bus.busy, 0);
        for (int k = 0; k < 4; k++) rd("auto_rx", 2'(k), tx_model[k]);
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.tx_we = 1'b0; bus.tx_idx = '0; bus.tx_wdata = '0; bus.rx_idx = '0;
`ifdef LNK_AUTO_RESTART_EN
        bus.auto_en = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin tx_model[k] = '0; s_out[k] = '0; s_in[k] = '0; end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");
        for (int k = 0; k < 4; k++) rd("reset_rx", 2'(k), 32'h0);

        loopback = 1'b1;
        wr(0, 32'h0000_0013); wr(1, 32'hDEAD_BEEF); wr(2, 32'h8000_0001); wr(3, 32'hFFFF_FFFF);
        run_frame(1'b0, 0);

        loopback = 1'b0;
        s_out[0] = 32'h4; s_out[1] = 32'h0; s_out[2] = 32'h100; s_out[3] = 32'hAB;
        wr(0, 32'h0000_0013);
        run_frame(1'b0, 0);
        chk("slave_slot1", s_in[1], 32'h13);

        loopback = 1'b1;
        wr(3, 32'h1234_5678);
        run_frame(1'b1, 0);
        chk("late_write_seg3", tx_model[3], 32'h55);

        run_frame(1'b0, 300);

        for (int r = 0; r < 17; r++) begin
            loopback = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                wr(2'(k), $urandom);
                s_out[k] = $urandom;
            end
            run_frame(1'b0, 0);
        end

`ifdef LNK_AUTO_RESTART_EN
        auto_test();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
